// File: rtl/result_unloader.sv
// Purpose : snapshots the nine 3x3 MAC accumulators on an unload_res rising edge and
//           streams the valid row_w x col_x results out row-major over valid/ready.
// Latency : first result valid the cycle after the capture edge; one transfer per cycle.
// Backpr. : o_data_out/o_out_idx/o_out_last hold while o_out_valid & ~i_out_ready.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_unload_res    level from mem_bank; its rising edge starts a capture
//   i_mac_res       nine accumulators, slot k = r*3+c at [k*ACC_W +: ACC_W]
//   i_row_w/i_col_x result dimensions (0..3), sampled at capture
//   i_out_ready     downstream accepts the presented result
//   o_out_valid, o_data_out, o_out_idx, o_out_last   result stream
//   o_busy          snapshot held, stream in progress
//   o_done          one-cycle pulse after the last transfer (or an empty matrix)
//   o_overrun       sticky: capture edge seen while not idle
module result_unloader #(
    parameter int ACC_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_unload_res,
    input  logic [9*ACC_W-1:0] i_mac_res,
    input  logic [1:0]         i_row_w,
    input  logic [1:0]         i_col_x,
    input  logic               i_out_ready,
    output logic               o_out_valid,
    output logic [ACC_W-1:0]   o_data_out,
    output logic [3:0]         o_out_idx,
    output logic               o_out_last,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_unload_d;
    logic [ACC_W-1:0]  r_snap [9];
    logic [1:0]        r_rows;
    logic [1:0]        r_cols;
    logic [1:0]        r_row;
    logic [1:0]        r_col;
    logic              r_valid;
    logic [ACC_W-1:0]  r_data;
    logic [3:0]        r_idx;
    logic              r_last;
    logic              r_overrun;

    logic              w_cap;
    logic              w_xfer;
    logic              w_empty;
    logic              w_start;
    logic              w_advance;
    logic [1:0]        w_row_nxt;
    logic [1:0]        w_col_nxt;
    logic [3:0]        w_idx_nxt;
    logic              w_last_nxt;

    // Only a rising edge captures; a level held high never retriggers.
    assign w_cap   = i_unload_res & ~r_unload_d;
    assign w_xfer  = r_valid & i_out_ready;
    assign w_empty = (i_row_w == 2'd0) || (i_col_x == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cap) begin
                    if (w_empty) begin
                        w_state_nxt = FIN;
                    end else begin
                        w_state_nxt = SEND;
                        w_start     = 1'b1;
                    end
                end
            end
            SEND: begin
                if (w_xfer) begin
                    if (r_last) begin
                        w_state_nxt = FIN;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Row-major walk over the captured rows x cols window of the 3x3 grid.
    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col + 2'd1;
        if (r_col == r_cols - 2'd1) begin
            w_col_nxt = 2'd0;
            w_row_nxt = r_row + 2'd1;
        end
        w_idx_nxt  = {2'b00, w_row_nxt} * 4'd3 + {2'b00, w_col_nxt};
        w_last_nxt = (w_row_nxt == r_rows - 2'd1) && (w_col_nxt == r_cols - 2'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_unload_d <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                r_snap[k] <= '0;
            end
            r_rows    <= 2'd0;
            r_cols    <= 2'd0;
            r_row     <= 2'd0;
            r_col     <= 2'd0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_idx     <= 4'd0;
            r_last    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_unload_d <= i_unload_res;
            if (w_cap && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (w_start) begin
                for (int k = 0; k < 9; k++) begin
                    r_snap[k] <= i_mac_res[k*ACC_W +: ACC_W];
                end
                r_rows  <= i_row_w;
                r_cols  <= i_col_x;
                r_row   <= 2'd0;
                r_col   <= 2'd0;
                r_valid <= 1'b1;
                // Slot 0 comes straight from the input: the snapshot loads this same edge.
                r_data  <= i_mac_res[ACC_W-1:0];
                r_idx   <= 4'd0;
                r_last  <= (i_row_w == 2'd1) && (i_col_x == 2'd1);
            end else if (w_advance) begin
                r_row  <= w_row_nxt;
                r_col  <= w_col_nxt;
                r_data <= r_snap[w_idx_nxt];
                r_idx  <= w_idx_nxt;
                r_last <= w_last_nxt;
            end else if (w_xfer) begin
                // Final element accepted: stream ends.
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_valid;
    assign o_data_out  = r_data;
    assign o_out_idx   = r_idx;
    assign o_out_last  = r_last;
    assign o_busy      = (r_state == SEND);
    assign o_done      = (r_state == FIN);
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_result_unloader.sv
module tb_result_unloader;

    localparam int ACC_W = 10;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               unload = 1'b0;
    logic [9*ACC_W-1:0] mac = '0;
    logic [1:0]         row_w = 2'd0;
    logic [1:0]         col_x = 2'd0;
    logic               ready = 1'b0;
    logic               out_valid;
    logic [ACC_W-1:0]   data_out;
    logic [3:0]         out_idx;
    logic               out_last;
    logic               busy;
    logic               done;
    logic               overrun;

    result_unloader #(.ACC_W(ACC_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_unload_res (unload),
        .i_mac_res    (mac),
        .i_row_w      (row_w),
        .i_col_x      (col_x),
        .i_out_ready  (ready),
        .o_out_valid  (out_valid),
        .o_data_out   (data_out),
        .o_out_idx    (out_idx),
        .o_out_last   (out_last),
        .o_busy       (busy),
        .o_done       (done),
        .o_overrun    (overrun)
    );

    always #5 clk = ~clk;

    // One stimulus record: dimensions, data pattern, ready mode (0 always, 1 random),
    // cycles unload_res stays high, cycle of an extra unload pulse (0 = none),
    // expected transfer count and expected overrun at the end.
    typedef struct {
        int rows;
        int cols;
        int pat;
        int rdy_mode;
        int hold;
        int pulse_at;
        int exp_n;
        int exp_ov;
    } vec_t;

    typedef struct {
        int idx;
        int data;
        int last;
    } item_t;

    item_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pat_val(input int pat, input int k);
        case (pat)
            0:       return k + 1;
            1:       return 10 * k;
            2:       return int'($urandom_range(0, 1023));
            default: return (k == 8) ? 1023 : k * 37;
        endcase
    endfunction

    task automatic run_vec(input vec_t v, input int tag);
        int    vals [9];
        int    n_xfer;
        int    n_done;
        int    done_cyc;
        int    last_pop;
        item_t it;
        for (int k = 0; k < 9; k++) begin
            vals[k] = pat_val(v.pat, k);
        end
        sb.delete();
        for (int r = 0; r < v.rows; r++) begin
            for (int c = 0; c < v.cols; c++) begin
                it.idx  = r * 3 + c;
                it.data = vals[r * 3 + c];
                it.last = ((r == v.rows - 1) && (c == v.cols - 1)) ? 1 : 0;
                sb.push_back(it);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            mac[k*ACC_W +: ACC_W] = ACC_W'(vals[k]);
        end
        row_w  = 2'(v.rows);
        col_x  = 2'(v.cols);
        unload = 1'b1;
        ready  = 1'b1;
        n_xfer   = 0;
        n_done   = 0;
        done_cyc = -1;
        last_pop = -1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            unload = (cyc < v.hold) || (cyc == v.pulse_at);
            // Scramble the accumulators: the captured snapshot must be unaffected.
            for (int k = 0; k < 9; k++) begin
                mac[k*ACC_W +: ACC_W] = ACC_W'($urandom_range(0, 1023));
            end
            ready = (v.rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            chk($sformatf("v%0d c%0d busy", tag, cyc), int'(busy), int'(out_valid));
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk($sformatf("v%0d c%0d extra_valid", tag, cyc), 1, 0);
                end else begin
                    it = sb[0];
                    chk($sformatf("v%0d c%0d idx", tag, cyc), int'(out_idx), it.idx);
                    chk($sformatf("v%0d c%0d data", tag, cyc), int'(data_out), it.data);
                    chk($sformatf("v%0d c%0d last", tag, cyc), int'(out_last), it.last);
                    if (ready) begin
                        void'(sb.pop_front());
                        n_xfer++;
                        last_pop = cyc;
                    end
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3 && cyc > v.hold && cyc > v.pulse_at) break;
        end
        chk($sformatf("v%0d transfers", tag), n_xfer, v.exp_n);
        chk($sformatf("v%0d done_count", tag), n_done, 1);
        chk($sformatf("v%0d done_cycle", tag), done_cyc, (v.exp_n == 0) ? 1 : last_pop + 1);
        chk($sformatf("v%0d overrun", tag), int'(overrun), v.exp_ov);
        chk($sformatf("v%0d left_in_sb", tag), sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [9];
        vecs[0] = '{3, 3, 0, 0, 1,  0, 9, 0};
        vecs[1] = '{2, 3, 1, 0, 1,  0, 6, 0};
        vecs[2] = '{3, 2, 1, 0, 1,  0, 6, 0};
        vecs[3] = '{2, 2, 2, 1, 1,  0, 4, 0};
        vecs[4] = '{1, 1, 0, 0, 20, 0, 1, 0};
        vecs[5] = '{0, 3, 0, 0, 1,  0, 0, 0};
        vecs[6] = '{3, 0, 0, 0, 1,  0, 0, 0};
        vecs[7] = '{3, 3, 3, 1, 1,  4, 9, 1};
        vecs[8] = '{1, 3, 2, 0, 1,  0, 3, 1};

        #2;
        chk("rst valid",   int'(out_valid), 0);
        chk("rst last",    int'(out_last),  0);
        chk("rst busy",    int'(busy),      0);
        chk("rst done",    int'(done),      0);
        chk("rst overrun", int'(overrun),   0);
        chk("rst data",    int'(data_out),  0);
        chk("rst idx",     int'(out_idx),   0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in the middle of a 3x3 stream after two transfers.
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            mac[k*ACC_W +: ACC_W] = ACC_W'(k + 1);
        end
        row_w  = 2'd3;
        col_x  = 2'd3;
        unload = 1'b1;
        ready  = 1'b1;
        @(negedge clk);
        unload = 1'b0;
        chk("mid idx0", int'(out_idx), 0);
        @(negedge clk);
        chk("mid idx1", int'(out_idx), 1);
        @(negedge clk);
        chk("mid idx2",   int'(out_idx),   2);
        chk("mid valid2", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst valid",   int'(out_valid), 0);
        chk("arst data",    int'(data_out),  0);
        chk("arst idx",     int'(out_idx),   0);
        chk("arst last",    int'(out_last),  0);
        chk("arst busy",    int'(busy),      0);
        chk("arst done",    int'(done),      0);
        chk("arst overrun", int'(overrun),   0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst no_done",  int'(done),      0);
            chk("arst no_valid", int'(out_valid), 0);
        end
        rst_n = 1'b1;
        run_vec(vecs[0], 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
